// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan-session controller:
//   - scan_state_e : controller FSM states
//   - SIG_W        : signature width
//   - MISR_POLY    : feedback polynomial of the signature register
//   - misr_next()  : one step of the signature register
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_UPDATE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } scan_state_e;

    // Shift left, fold the outgoing MSB back through the polynomial and
    // inject the new serial bit at the LSB.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic             b);
        logic [SIG_W-1:0] fb;
        fb = s[SIG_W-1] ? MISR_POLY : '0;
        return {s[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/scan_misr.sv
// -----------------------------------------------------------------------------
// scan_misr
// 16-bit signature register that compacts the serial scan-out stream.
// Ports:
//   CK   in   clock (rising edge)
//   RST  in   synchronous active-high reset, clears the signature
//   clr  in   clears the signature; wins over en
//   en   in   advance the signature by one bit this cycle
//   din  in   serial bit folded into the signature
//   sig  out  current signature (registered)
// -----------------------------------------------------------------------------
module scan_misr
    import scan_pkg::*;
(
    input  logic             CK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_next(sig_q, din);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/scan_session_ctrl.sv
// -----------------------------------------------------------------------------
// scan_session_ctrl
// Runs one scan session per start request: shifts an N-bit pattern in from
// si while the previous response leaves on so, applies the pattern to the
// circuit state, waits CAPT_WAIT cycles, captures the circuit's next state
// and signals done. Every bit leaving on so is compacted into a MISR.
//
// Handshake: start is a level request honoured only while busy=0 (IDLE);
// so is meaningful only while so_valid=1; apply and done are one-cycle
// pulses; capture_in is sampled only in the CAPTURE cycle.
//
// Ports:
//   CK, RST     clock and synchronous active-high reset
//   start       session request
//   si          serial pattern in (first bit lands in state_out[0])
//   so/so_valid serial response out and its qualifier
//   state_out   pattern driven onto the circuit state
//   apply       state_out was updated this cycle
//   capture_in  circuit next-state response
//   done        end-of-session pulse
//   busy        controller not in IDLE
//   sig_clr     clear the signature
//   sig         MISR signature
//   state_dbg   current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module scan_session_ctrl
    import scan_pkg::*;
#(
    parameter int N         = 19,
    parameter int CAPT_WAIT = 1,
    parameter int CNT_W     = $clog2(N + 1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic             si,
    output logic             so,
    output logic             so_valid,
    output logic [N-1:0]     state_out,
    output logic             apply,
    input  logic [N-1:0]     capture_in,
    output logic             done,
    output logic             busy,
    input  logic             sig_clr,
    output logic [SIG_W-1:0] sig,
    output logic [2:0]       state_dbg
);

    // The wait counter runs 0..CAPT_WAIT-1; keep it at least one bit wide so
    // CAPT_WAIT of 0 or 1 still elaborates cleanly.
    localparam int WAIT_W = (CAPT_WAIT > 1) ? $clog2(CAPT_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (CAPT_WAIT > 0) ? WAIT_W'(CAPT_WAIT - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);

    scan_state_e       state_q, state_d;
    logic [N-1:0]      sr_q, sr_d;
    logic [N-1:0]      state_out_q, state_out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic [N-1:0]      sr_shifted;

    assign sr_shifted = {si, sr_q[N-1:1]};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        state_out_d = state_out_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_shifted;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_UPDATE;
                    // The pattern completes on this edge; latching the
                    // shifted value here makes it visible during UPDATE.
                    state_out_d = sr_shifted;
                end
            end
            ST_UPDATE: begin
                wcnt_d = '0;
                if (CAPT_WAIT > 0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            ST_CAPTURE: begin
                sr_d    = capture_in;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            state_out_q <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            state_out_q <= state_out_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign so_valid  = (state_q == ST_SHIFT);
    assign so        = so_valid & sr_q[0];
    assign apply     = (state_q == ST_UPDATE);
    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign state_out = state_out_q;
    assign state_dbg = state_q;

    scan_misr u_misr (
        .CK  (CK),
        .RST (RST),
        .clr (sig_clr),
        .en  (so_valid),
        .din (so),
        .sig (sig)
    );

endmodule

// File: tb/tb_scan_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_session_ctrl
// Two controllers share every input: u_dut1 has CAPT_WAIT=1, u_dut0 has
// CAPT_WAIT=0. 'sel' picks which one's outputs are observed. The reference
// model holds the previous captured response, the applied pattern and the
// expected signature; per-cycle expectations come from the session timeline.
// -----------------------------------------------------------------------------
module tb_scan_session_ctrl;

    localparam int N = 19;

    logic          CK;
    logic          RST;
    logic          start;
    logic          si;
    logic          sig_clr;
    logic [N-1:0]  capture_in;

    logic          so1, so_valid1, apply1, done1, busy1;
    logic [N-1:0]  state_out1;
    logic [15:0]   sig1;
    logic [2:0]    state_dbg1;
    logic          so0, so_valid0, apply0, done0, busy0;
    logic [N-1:0]  state_out0;
    logic [15:0]   sig0;
    logic [2:0]    state_dbg0;

    logic          sel;
    logic          obs_so, obs_so_valid, obs_apply, obs_done, obs_busy;
    logic [N-1:0]  obs_state_out;
    logic [15:0]   obs_sig;

    // reference model state
    logic [N-1:0]  m_prev_cap;
    logic [N-1:0]  m_state_out;
    logic [15:0]   m_sig;

    int n_checks;
    int n_fail;

    scan_session_ctrl #(.N(N), .CAPT_WAIT(1)) u_dut1 (
        .CK(CK), .RST(RST), .start(start), .si(si), .so(so1), .so_valid(so_valid1),
        .state_out(state_out1), .apply(apply1), .capture_in(capture_in), .done(done1),
        .busy(busy1), .sig_clr(sig_clr), .sig(sig1), .state_dbg(state_dbg1)
    );

    scan_session_ctrl #(.N(N), .CAPT_WAIT(0)) u_dut0 (
        .CK(CK), .RST(RST), .start(start), .si(si), .so(so0), .so_valid(so_valid0),
        .state_out(state_out0), .apply(apply0), .capture_in(capture_in), .done(done0),
        .busy(busy0), .sig_clr(sig_clr), .sig(sig0), .state_dbg(state_dbg0)
    );

    // clock / reset block
    initial CK = 1'b0;
    always #5 CK = ~CK;

    always_comb begin
        if (sel) begin
            obs_so = so1; obs_so_valid = so_valid1; obs_apply = apply1; obs_done = done1;
            obs_busy = busy1; obs_state_out = state_out1; obs_sig = sig1;
        end else begin
            obs_so = so0; obs_so_valid = so_valid0; obs_apply = apply0; obs_done = done0;
            obs_busy = busy0; obs_state_out = state_out0; obs_sig = sig0;
        end
    end

    // Signature polynomial x^16 + x^12 + x^5 + 1, one serial bit per step.
    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
    endfunction

    task automatic model_reset();
        m_prev_cap  = '0;
        m_state_out = '0;
        m_sig       = '0;
    endtask

    task automatic idle(input int n);
        start   = 1'b0;
        sig_clr = 1'b0;
        repeat (n) begin
            @(posedge CK); #1;
        end
    endtask

    // One full session, cycle 0 (start sample) through the DONE cycle.
    // Entered and left just after a rising edge.
    task automatic run_session(input logic [N-1:0] pat, input logic [N-1:0] cap,
                               input int cw, input bit hold_start, input int clr_at,
                               input string tag);
        int   last;
        logic exp_busy, exp_valid, exp_so, exp_apply, exp_done;
        logic [N-1:0] out_bits;
        last     = N + 3 + cw;
        out_bits = m_prev_cap;
        for (int k = 0; k <= last; k++) begin
            start      = (k == 0) || hold_start;
            si         = (k >= 1 && k <= N) ? pat[k-1] : 1'($urandom_range(0, 1));
            capture_in = (k >= N + 2) ? cap : N'($urandom);
            sig_clr    = (k == clr_at);
            if (k == N + 1) m_state_out = pat;
            exp_busy  = (k >= 1);
            exp_valid = (k >= 1) && (k <= N);
            exp_so    = exp_valid ? out_bits[k-1] : 1'b0;
            exp_apply = (k == N + 1);
            exp_done  = (k == last);
            @(negedge CK);
            n_checks++;
            if (obs_busy !== exp_busy) begin
                n_fail++; $display("FAIL %s busy c%0d: got %b want %b", tag, k, obs_busy, exp_busy);
            end
            n_checks++;
            if (obs_so_valid !== exp_valid) begin
                n_fail++; $display("FAIL %s so_valid c%0d: got %b want %b", tag, k, obs_so_valid, exp_valid);
            end
            n_checks++;
            if (obs_so !== exp_so) begin
                n_fail++; $display("FAIL %s so c%0d: got %b want %b", tag, k, obs_so, exp_so);
            end
            n_checks++;
            if (obs_apply !== exp_apply) begin
                n_fail++; $display("FAIL %s apply c%0d: got %b want %b", tag, k, obs_apply, exp_apply);
            end
            n_checks++;
            if (obs_done !== exp_done) begin
                n_fail++; $display("FAIL %s done c%0d: got %b want %b", tag, k, obs_done, exp_done);
            end
            n_checks++;
            if (obs_state_out !== m_state_out) begin
                n_fail++; $display("FAIL %s state_out c%0d: got %h want %h", tag, k, obs_state_out, m_state_out);
            end
            n_checks++;
            if (obs_sig !== m_sig) begin
                n_fail++; $display("FAIL %s sig c%0d: got %h want %h", tag, k, obs_sig, m_sig);
            end
            // signature advance on the edge closing this cycle
            if (sig_clr) m_sig = '0;
            else if (exp_valid) m_sig = misr_ref(m_sig, exp_so);
            @(posedge CK); #1;
        end
        start      = 1'b0;
        sig_clr    = 1'b0;
        m_prev_cap = cap;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CK);
        #1 RST = 1'b0;
        model_reset();
        @(negedge CK);
        n_checks++;
        if ({so1, so_valid1, apply1, done1, busy1} !== 5'b0) begin
            n_fail++; $display("FAIL reset ctrl1: got %b want 00000", {so1, so_valid1, apply1, done1, busy1});
        end
        n_checks++;
        if (state_out1 !== '0) begin
            n_fail++; $display("FAIL reset state_out1: got %h want 0", state_out1);
        end
        n_checks++;
        if (sig1 !== 16'h0) begin
            n_fail++; $display("FAIL reset sig1: got %h want 0", sig1);
        end
        n_checks++;
        if ({so0, so_valid0, apply0, done0, busy0} !== 5'b0) begin
            n_fail++; $display("FAIL reset ctrl0: got %b want 00000", {so0, so_valid0, apply0, done0, busy0});
        end
        n_checks++;
        if (state_out0 !== '0) begin
            n_fail++; $display("FAIL reset state_out0: got %h want 0", state_out0);
        end
        n_checks++;
        if (sig0 !== 16'h0) begin
            n_fail++; $display("FAIL reset sig0: got %h want 0", sig0);
        end
        @(posedge CK); #1;
    endtask

    task automatic test_single();
        sel = 1'b1;
        run_session(19'h5A5A5, 19'h00001, 1, 1'b0, -1, "single");
        idle(2);
    endtask

    task automatic test_unload();
        sel     = 1'b1;
        sig_clr = 1'b1;
        @(posedge CK); #1;
        sig_clr = 1'b0;
        m_sig   = '0;
        run_session(N'($urandom), N'($urandom), 1, 1'b0, -1, "unload");
        @(negedge CK);
        n_checks++;
        if (obs_sig !== 16'h4084) begin
            n_fail++; $display("FAIL unload final_sig: got %h want 4084", obs_sig);
        end
        @(posedge CK); #1;
    endtask

    task automatic test_random();
        int clr_at;
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N + 4)) : -1;
            run_session(N'($urandom), N'($urandom), 1, 1'b0, clr_at, "random");
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_session(N'($urandom), N'($urandom), 0, 1'b1, -1, "b2b");
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] pat;
        sel = 1'b1;
        RST = 1'b1;
        repeat (2) @(posedge CK);
        #1 RST = 1'b0;
        model_reset();
        pat = N'($urandom);
        for (int k = 0; k <= 7; k++) begin
            start      = (k == 0);
            si         = (k >= 1) ? pat[k-1] : 1'b0;
            capture_in = N'($urandom);
            RST        = (k == 7);
            @(negedge CK);
            if (k >= 1) begin
                n_checks++;
                if (obs_so_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rst_mid shifting c%0d: got %b want 1", k, obs_so_valid);
                end
            end
            @(posedge CK); #1;
        end
        RST   = 1'b0;
        start = 1'b0;
        model_reset();
        for (int j = 0; j < 6; j++) begin
            @(negedge CK);
            n_checks++;
            if ({obs_so, obs_so_valid, obs_apply, obs_done, obs_busy} !== 5'b0) begin
                n_fail++; $display("FAIL rst_mid ctrl c%0d: got %b want 00000", j,
                                   {obs_so, obs_so_valid, obs_apply, obs_done, obs_busy});
            end
            n_checks++;
            if (obs_state_out !== '0) begin
                n_fail++; $display("FAIL rst_mid state_out c%0d: got %h want 0", j, obs_state_out);
            end
            n_checks++;
            if (obs_sig !== 16'h0) begin
                n_fail++; $display("FAIL rst_mid sig c%0d: got %h want 0", j, obs_sig);
            end
            @(posedge CK); #1;
        end
        run_session(N'($urandom), N'($urandom), 1, 1'b0, -1, "post_rst");
        run_session(N'($urandom), N'($urandom), 1, 1'b0, -1, "post_rst2");
        idle(2);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        RST        = 1'b1;
        start      = 1'b0;
        si         = 1'b0;
        sig_clr    = 1'b0;
        capture_in = '0;
        sel        = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_unload();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_session_ctrl.md
# scan_session_ctrl

Scan-session controller that sits between the test harness and the state register of a sequential benchmark circuit. It shifts a serial test pattern into an N-bit scan register and drives that pattern onto the circuit's flip-flop state. It then captures the circuit's next-state response and shifts that response out serially in the next session. A 16-bit MISR compacts every bit that leaves on the serial output.

## Interface
Parameters:
- N, 19: scan length, equal to the number of state flip-flops in the circuit under test.
- CAPT_WAIT, 1: number of cycles between applying the pattern and capturing the response. 0 is legal.
- CNT_W, ceil(log2(N+1)): width of the shift counter.

Ports:
- CK  in  1  clock; all state updates happen on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request to begin a session; sampled only in IDLE.
- si  in  1  serial pattern input.
- so  out  1  serial response output.
- so_valid  out  1  high while `so` carries a response bit.
- state_out  out  N  pattern driven onto the circuit's state inputs.
- apply  out  1  one-cycle pulse; `state_out` was updated this cycle.
- capture_in  in  N  next-state response from the circuit.
- done  out  1  one-cycle pulse marking the end of a session.
- busy  out  1  high in every state except IDLE.
- sig_clr  in  1  clears the MISR signature.
- sig  out  16  MISR signature.

## Operation
- States: IDLE, SHIFT, UPDATE, WAIT, CAPTURE, DONE.
- Internal registers: scan register `sr[N-1:0]`, shift counter `cnt`, wait counter.
- IDLE: if `start`=1, go to SHIFT and load `cnt`=0.
- SHIFT, one bit per cycle:
  - `so` = `sr[0]`, `so_valid`=1.
  - `sr` <= {`si`, `sr[N-1:1]`}.
  - `cnt`++.
  - Leave after the N-th bit: go to UPDATE when `cnt`=N-1.
  - The first `si` bit ends up in `sr[0]`.
- UPDATE: `state_out` <= `sr`, `apply`=1. Next state is WAIT if CAPT_WAIT>0, otherwise CAPTURE.
- WAIT: hold for exactly CAPT_WAIT cycles, then go to CAPTURE.
- CAPTURE: `sr` <= `capture_in`.
- DONE: `done`=1, then return to IDLE.
- MISR update, on each SHIFT cycle only:
  - `sig` <= {`sig[14:0]`,0} ^ (`sig[15]` ? 16'h1021 : 0) ^ {15'b0, `so`}.
  - `sig_clr` forces `sig` to 0 and has priority over the update.
- `start` is ignored whenever `busy`=1, including in the DONE cycle. `start` held high from DONE is sampled again in the following IDLE cycle.
- `si` is ignored outside SHIFT.
- `capture_in` is sampled only in CAPTURE.
- `state_out` holds its value between UPDATE cycles.
- RST, in any state (mid-shift included):
  - State goes to IDLE.
  - `sr`, `state_out`, `sig` and all counters go to 0.
  - `so`, `so_valid`, `apply`, `done` and `busy` go to 0.
  - No partial pattern is applied.
- Reset value of every output is 0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
- SHIFT occupies cycles 1..N.
- UPDATE is cycle N+1; `apply` is high and the new `state_out` is visible in that cycle.
- WAIT occupies cycles N+2..N+1+CAPT_WAIT.
- CAPTURE is cycle N+2+CAPT_WAIT.
- DONE is cycle N+3+CAPT_WAIT; `done` is high in that cycle.
- Earliest next `start` sample: cycle N+4+CAPT_WAIT.
- Session length: N+4+CAPT_WAIT cycles from one `start` sample to the next.
- All outputs come from registers or decode of the registered state; there is no combinational path from input to output.
- The bit shifted out at SHIFT cycle k is the captured response bit `capture_in[k-1]` from the previous session.

## Structure
- Package `scan_pkg` holds:
  - the state enum,
  - MISR_POLY = 16'h1021,
  - SIG_W = 16.
- Sub-module `scan_misr` (CK, RST, clr, en, din, sig) holds the signature logic. The controller instantiates it with `en` = SHIFT state and `din` = `so`.
- The FSM, the scan register and the counters stay in `scan_session_ctrl`.

## Test plan
- Reset: assert RST for 2 cycles, then check that every output is 0 and `busy`=0.
- Single session (N=19, CAPT_WAIT=1):
  - Stimulus: shift in 19'h5A5A5, first bit = LSB, with `capture_in`=19'h00001.
  - Expect `apply` at cycle 20 with `state_out`=19'h5A5A5.
  - Expect `done` at cycle 23.
  - Expect `so`=0 throughout SHIFT.
- Unload and signature:
  - Stimulus: pulse `sig_clr`, then run a second session.
  - Expect `so`=1 in SHIFT cycle 1 and 0 in the remaining 18 cycles.
  - Expect `sig`=16'h4084 after the session.
- Back-to-back sessions with CAPT_WAIT=0:
  - Stimulus: `start` held high.
  - Expect `done` every 23 cycles, `apply` exactly N+1 cycles after each `start` sample, and `start` ignored during DONE.
- Reset mid-operation:
  - Stimulus: assert RST at SHIFT cycle 7, then start a fresh session.
  - Expect IDLE and all-zero outputs the next cycle, `state_out` still 0, no `apply` pulse, and a correct pattern applied by the new session.
